// File: rtl/soc_bus_fabric_if.sv
// Bus bundle between one master, the fabric and N_SLV peripheral slots.
// The master modport is the fabric's own view; the slave modport is the mirror used by the surroundings.
interface soc_bus_fabric_if #(
  parameter int N_SLV       = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 12
);
  logic                    m_valid;
  logic                    m_write;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_err;
  logic [N_SLV-1:0]        s_valid;
  logic                    s_write;
  logic [REGION_BITS-1:0]  s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;
  logic [7:0]              err_cnt;

  modport master (
    input  m_valid, m_write, m_addr, m_wdata, s_rdata, s_ready,
    output m_ready, m_rdata, m_err, s_valid, s_write, s_addr, s_wdata, err_cnt
  );

  modport slave (
    output m_valid, m_write, m_addr, m_wdata, s_rdata, s_ready,
    input  m_ready, m_rdata, m_err, s_valid, s_write, s_addr, s_wdata, err_cnt
  );
endinterface

// File: rtl/soc_bus_fabric.sv
// Single-master, N_SLV-slot peripheral fabric: address decode, valid/ready forwarding,
// slave timeout and error response with a saturating error counter.
module soc_bus_fabric #(
  parameter int                N_SLV       = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                REGION_BITS = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                TIMEOUT     = 16
) (
  input  logic clk,
  input  logic rst_n,
  soc_bus_fabric_if.master bus
);
  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // One bit wider than the address so the full slot span is representable.
  localparam logic [ADDR_W:0]    SPAN     = (ADDR_W+1)'(N_SLV) << REGION_BITS;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [N_SLV-1:0]   ONE      = N_SLV'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  logic [1:0]             state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [TMR_W-1:0]       timer_r;
  logic                   m_ready_r;
  logic [DATA_W-1:0]      m_rdata_r;
  logic                   m_err_r;
  logic [N_SLV-1:0]       s_valid_r;
  logic                   s_write_r;
  logic [REGION_BITS-1:0] s_addr_r;
  logic [DATA_W-1:0]      s_wdata_r;
  logic [7:0]             err_cnt_r;

  logic [ADDR_W-1:0]      offset_s;
  logic                   hit_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   sel_ready_s;
  logic [DATA_W-1:0]      sel_rdata_s;

  // Address decode of the incoming request and selection of the active slave's response.
  always_comb begin
    offset_s    = bus.m_addr - BASE_ADDR;
    hit_s       = ({1'b0, offset_s} < SPAN);
    idx_s       = IDX_W'(offset_s >> REGION_BITS);
    sel_ready_s = 1'b0;
    sel_rdata_s = '0;
    if (32'(idx_r) < N_SLV) begin
      sel_ready_s = bus.s_ready[idx_r];
      sel_rdata_s = bus.s_rdata[idx_r*DATA_W +: DATA_W];
    end else begin
      sel_ready_s = 1'b0;
      sel_rdata_s = '0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      timer_r   <= '0;
      m_ready_r <= 1'b0;
      m_rdata_r <= '0;
      m_err_r   <= 1'b0;
      s_valid_r <= '0;
      s_write_r <= 1'b0;
      s_addr_r  <= '0;
      s_wdata_r <= '0;
      err_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          m_ready_r <= 1'b0;
          if (bus.m_valid) begin
            s_write_r <= bus.m_write;
            s_addr_r  <= bus.m_addr[REGION_BITS-1:0];
            s_wdata_r <= bus.m_wdata;
            idx_r     <= idx_s;
            timer_r   <= '0;
            if (hit_s) begin
              s_valid_r <= ONE << idx_s;
              state_r   <= ACCESS;
            end else begin
              m_ready_r <= 1'b1;
              m_rdata_r <= '0;
              m_err_r   <= 1'b1;
              err_cnt_r <= sat_inc(err_cnt_r);
              state_r   <= RESP;
            end
          end
        end
        ACCESS: begin
          // A ready on the timeout edge still counts as a normal completion.
          if (sel_ready_s) begin
            s_valid_r <= '0;
            m_ready_r <= 1'b1;
            m_rdata_r <= s_write_r ? '0 : sel_rdata_s;
            m_err_r   <= 1'b0;
            state_r   <= RESP;
          end else if (timer_r == TMR_LAST) begin
            s_valid_r <= '0;
            m_ready_r <= 1'b1;
            m_rdata_r <= '0;
            m_err_r   <= 1'b1;
            err_cnt_r <= sat_inc(err_cnt_r);
            state_r   <= RESP;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        RESP: begin
          m_ready_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          m_ready_r <= 1'b0;
          s_valid_r <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_ready = m_ready_r;
  assign bus.m_rdata = m_rdata_r;
  assign bus.m_err   = m_err_r;
  assign bus.s_valid = s_valid_r;
  assign bus.s_write = s_write_r;
  assign bus.s_addr  = s_addr_r;
  assign bus.s_wdata = s_wdata_r;
  assign bus.err_cnt = err_cnt_r;
endmodule
